// File: rtl/marks_access_arbiter.sv
// Arbitrated owner of the math/physics/lab marks registers: teacher and principal
// writers share a round-robin req/gnt path, students read through an independent port.
module marks_access_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_req,
  input  logic [1:0]       t_field,
  input  logic [WIDTH-1:0] t_wdata,
  output logic             t_gnt,
  output logic             t_err,
  input  logic             p_req,
  input  logic [WIDTH-1:0] p_wdata,
  output logic             p_gnt,
  input  logic             s_req,
  input  logic [1:0]       s_field,
  output logic [WIDTH-1:0] s_rdata,
  output logic             s_valid,
  output logic [WIDTH-1:0] math_q,
  output logic [WIDTH-1:0] physics_q,
  output logic [WIDTH-1:0] lab_q,
  output logic             lab_locked,
  output logic [CNT_W-1:0] commit_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ptr;    // 1 = principal wins the next tie
  logic                  r_owner;  // 1 = principal owns the current grant
  logic [1:0]            r_field;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_lab_locked;
  logic [CNT_W-1:0]      r_commit_cnt;
  logic                  r_s_valid;
  logic [WIDTH-1:0]      r_s_rdata;
  logic [2:0][WIDTH-1:0] w_marks;
  logic [2:0]            w_wr_en;
  logic                  w_pick_p;
  logic                  w_t_allow;
  logic                  w_commit;
  logic [WIDTH-1:0]      w_s_mux;

  assign w_pick_p  = p_req & (~t_req | r_ptr);
  assign w_t_allow = (r_field == 2'd0) | (r_field == 2'd1) |
                     ((r_field == 2'd2) & ~r_lab_locked);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_field <= 2'd0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && (t_req | p_req)) begin
        // The principal can only ever target lab, so its request is latched as field 2.
        r_owner <= w_pick_p;
        r_field <= w_pick_p ? 2'd2 : t_field;
        r_wdata <= w_pick_p ? p_wdata : t_wdata;
      end
      if (r_state == ST_GRANT) begin
        r_ptr <= ~r_owner;
      end
    end
  end

  // Handshake pulses are suppressed while rst is high so an aborted grant never shows.
  always_comb begin
    w_state_next = r_state;
    t_gnt        = 1'b0;
    t_err        = 1'b0;
    p_gnt        = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (t_req | p_req) begin
          w_state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_state_next = ST_IDLE;
        if (!rst) begin
          if (r_owner) begin
            p_gnt    = 1'b1;
            w_commit = 1'b1;
          end else if (w_t_allow) begin
            t_gnt    = 1'b1;
            w_commit = 1'b1;
          end else begin
            t_err = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_marks
      logic [WIDTH-1:0] r_mark;
      assign w_wr_en[gi] = w_commit & (r_field == 2'(gi));
      assign w_marks[gi] = r_mark;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mark <= '0;
        end else if (w_wr_en[gi]) begin
          r_mark <= r_wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lab_locked <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      if (p_gnt) begin
        r_lab_locked <= 1'b1;
      end
      if (w_commit && r_commit_cnt != {CNT_W{1'b1}}) begin
        r_commit_cnt <= r_commit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_s_mux = '0;
    case (s_field)
      2'd0:    w_s_mux = w_marks[0];
      2'd1:    w_s_mux = w_marks[1];
      2'd2:    w_s_mux = w_marks[2];
      default: w_s_mux = '0;
    endcase
  end

  // Reads sample the register before any write committing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_valid <= 1'b0;
      r_s_rdata <= '0;
    end else begin
      r_s_valid <= s_req;
      if (s_req) begin
        r_s_rdata <= w_s_mux;
      end
    end
  end

  assign math_q     = w_marks[0];
  assign physics_q  = w_marks[1];
  assign lab_q      = w_marks[2];
  assign lab_locked = r_lab_locked;
  assign commit_cnt = r_commit_cnt;
  assign s_valid    = r_s_valid;
  assign s_rdata    = r_s_rdata;

endmodule

// File: tb/tb_marks_access_arbiter.sv
// Self-checking bench for marks_access_arbiter: directed vector table, hand-written
// corner sequences and a randomized phase compared against a behavioural model.
module tb_marks_access_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         t_req, p_req, s_req;
  logic [1:0]   t_field, s_field;
  logic [W-1:0] t_wdata, p_wdata;
  logic         t_gnt, t_err, p_gnt, s_valid, lab_locked;
  logic [W-1:0] s_rdata, math_q, physics_q, lab_q;
  logic [7:0]   commit_cnt;

  logic         t_gnt2, t_err2, p_gnt2, s_valid2, lab_locked2;
  logic [W-1:0] s_rdata2, math_q2, physics_q2, lab_q2;
  logic [1:0]   commit_cnt2;

  always #5 clk = ~clk;

  marks_access_arbiter #(.WIDTH(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .t_req(t_req), .t_field(t_field), .t_wdata(t_wdata), .t_gnt(t_gnt), .t_err(t_err),
    .p_req(p_req), .p_wdata(p_wdata), .p_gnt(p_gnt),
    .s_req(s_req), .s_field(s_field), .s_rdata(s_rdata), .s_valid(s_valid),
    .math_q(math_q), .physics_q(physics_q), .lab_q(lab_q),
    .lab_locked(lab_locked), .commit_cnt(commit_cnt)
  );

  marks_access_arbiter #(.WIDTH(W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst),
    .t_req(t_req), .t_field(t_field), .t_wdata(t_wdata), .t_gnt(t_gnt2), .t_err(t_err2),
    .p_req(p_req), .p_wdata(p_wdata), .p_gnt(p_gnt2),
    .s_req(s_req), .s_field(s_field), .s_rdata(s_rdata2), .s_valid(s_valid2),
    .math_q(math_q2), .physics_q(physics_q2), .lab_q(lab_q2),
    .lab_locked(lab_locked2), .commit_cnt(commit_cnt2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [W-1:0] m_reg [3];
  logic         m_lock, m_ptr, m_busy, m_who;
  logic [1:0]   m_field;
  logic [W-1:0] m_data;
  int           m_cnt;
  logic         m_sval;
  logic [W-1:0] m_srd;
  bit           chk_en = 1'b0;

  function automatic logic allowed(input logic [1:0] f, input logic lock);
    return (f < 2'd2) || (f == 2'd2 && !lock);
  endfunction

  function automatic logic [W-1:0] peek(input logic [1:0] f);
    return (f == 2'd3) ? '0 : m_reg[f];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m_reg[i] <= '0;
      m_lock <= 1'b0; m_ptr <= 1'b0; m_busy <= 1'b0; m_who <= 1'b0;
      m_field <= 2'd0; m_data <= '0; m_cnt <= 0; m_sval <= 1'b0; m_srd <= '0;
    end else begin
      m_sval <= s_req;
      if (s_req) m_srd <= peek(s_field);
      if (m_busy) begin
        m_busy <= 1'b0;
        m_ptr  <= ~m_who;
        if (m_who) begin
          m_reg[2] <= m_data;
          m_lock   <= 1'b1;
          m_cnt    <= (m_cnt < 255) ? m_cnt + 1 : m_cnt;
        end else if (allowed(m_field, m_lock)) begin
          m_reg[m_field] <= m_data;
          m_cnt          <= (m_cnt < 255) ? m_cnt + 1 : m_cnt;
        end
      end else if (t_req || p_req) begin
        m_busy  <= 1'b1;
        m_who   <= (t_req && p_req) ? m_ptr : p_req;
        m_field <= t_field;
        m_data  <= ((t_req && p_req) ? m_ptr : p_req) ? p_wdata : t_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_t_gnt", t_gnt, !rst && m_busy && !m_who && allowed(m_field, m_lock));
      check("m_t_err", t_err, !rst && m_busy && !m_who && !allowed(m_field, m_lock));
      check("m_p_gnt", p_gnt, !rst && m_busy && m_who);
      check("m_s_valid", s_valid, m_sval);
      check("m_s_rdata", s_rdata, m_srd);
      check("m_math", math_q, m_reg[0]);
      check("m_physics", physics_q, m_reg[1]);
      check("m_lab", lab_q, m_reg[2]);
      check("m_lock", lab_locked, m_lock);
      check("m_cnt", commit_cnt, m_cnt);
      check("m_cnt_sat", commit_cnt2, (m_cnt > 3) ? 3 : m_cnt);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_write(input bit is_p, input logic [1:0] f, input logic [7:0] d,
                          output bit got_gnt, output bit got_err, output int lat);
    got_gnt = 1'b0; got_err = 1'b0; lat = 0;
    if (is_p) begin p_req = 1'b1; p_wdata = d; end
    else begin t_req = 1'b1; t_field = f; t_wdata = d; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (is_p ? p_gnt : (t_gnt | t_err)) begin
        got_gnt = is_p ? p_gnt : t_gnt;
        got_err = is_p ? 1'b0 : t_err;
        break;
      end
      lat++;
    end
    @(posedge clk); #1;
    t_req = 1'b0; p_req = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] f, input logic [7:0] exp);
    s_req = 1'b1; s_field = f;
    @(posedge clk); #1;
    s_req = 1'b0;
    @(negedge clk);
    check("rd_valid", s_valid, 1);
    check("rd_data", s_rdata, exp);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_valid_drop", s_valid, 0);
    check("rd_hold", s_rdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit         is_p;
    logic [1:0] field;
    logic [7:0] data;
    bit         exp_err;
    logic [7:0] e_math, e_phys, e_lab;
    bit         e_lock;
    int         e_cnt;
  } vec_t;

  vec_t vecs [6];
  bit   g, e;
  int   lat;
  bit   saw_t, saw_p;

  initial begin
    vecs[0] = '{1'b0, 2'd0, 8'd85, 1'b0, 8'd85, 8'd0,  8'd0,  1'b0, 1};
    vecs[1] = '{1'b0, 2'd1, 8'd90, 1'b0, 8'd85, 8'd90, 8'd0,  1'b0, 2};
    vecs[2] = '{1'b0, 2'd2, 8'd95, 1'b0, 8'd85, 8'd90, 8'd95, 1'b0, 3};
    vecs[3] = '{1'b1, 2'd2, 8'd99, 1'b0, 8'd85, 8'd90, 8'd99, 1'b1, 4};
    vecs[4] = '{1'b0, 2'd2, 8'd50, 1'b1, 8'd85, 8'd90, 8'd99, 1'b1, 4};
    vecs[5] = '{1'b0, 2'd3, 8'd33, 1'b1, 8'd85, 8'd90, 8'd99, 1'b1, 4};

    rst = 1'b1; t_req = 1'b0; p_req = 1'b0; s_req = 1'b0;
    t_field = 2'd0; s_field = 2'd0; t_wdata = '0; p_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_math", math_q, 0);
    check("rst_lab", lab_q, 0);
    check("rst_lock", lab_locked, 0);
    check("rst_cnt", commit_cnt, 0);
    check("rst_pulses", {t_gnt, t_err, p_gnt, s_valid}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].is_p, vecs[i].field, vecs[i].data, g, e, lat);
      $display("vec %0d: is_p=%0d field=%0d data=%0d gnt=%0d err=%0d lat=%0d",
               i, vecs[i].is_p, vecs[i].field, vecs[i].data, g, e, lat);
      check("vec_lat", lat, 1);
      check("vec_gnt", g, !vecs[i].exp_err);
      check("vec_err", e, vecs[i].exp_err);
      @(negedge clk);
      check("vec_math", math_q, vecs[i].e_math);
      check("vec_phys", physics_q, vecs[i].e_phys);
      check("vec_lab", lab_q, vecs[i].e_lab);
      check("vec_lock", lab_locked, vecs[i].e_lock);
      check("vec_cnt", commit_cnt, vecs[i].e_cnt);
      @(posedge clk); #1;
    end

    do_read(2'd2, 8'd99);
    do_read(2'd0, 8'd85);
    do_read(2'd3, 8'd0);

    // simultaneous requests from reset pointer: teacher first, principal two cycles later
    pulse_rst();
    t_req = 1'b1; t_field = 2'd0; t_wdata = 8'd11; p_req = 1'b1; p_wdata = 8'd77;
    @(posedge clk); #1;
    @(negedge clk);
    check("pair1_t_gnt", t_gnt, 1);
    check("pair1_p_wait", p_gnt, 0);
    @(posedge clk); #1; t_req = 1'b0;
    @(negedge clk);
    check("pair1_gap", p_gnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("pair1_p_gnt", p_gnt, 1);
    @(posedge clk); #1; p_req = 1'b0;
    @(negedge clk);
    check("pair1_math", math_q, 11);
    check("pair1_lab", lab_q, 77);
    @(posedge clk); #1;
    $display("pair1 done: math=%0d lab=%0d", math_q, lab_q);

    // a solo teacher grant leaves the pointer on principal for the next tie
    do_write(1'b0, 2'd1, 8'd20, g, e, lat);
    check("solo_gnt", g, 1);
    t_req = 1'b1; t_field = 2'd0; t_wdata = 8'd12; p_req = 1'b1; p_wdata = 8'd78;
    @(posedge clk); #1;
    @(negedge clk);
    check("pair2_p_first", p_gnt, 1);
    check("pair2_t_wait", t_gnt, 0);
    @(posedge clk); #1; p_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pair2_t_gnt", t_gnt, 1);
    @(posedge clk); #1; t_req = 1'b0;
    $display("pair2 done: math=%0d lab=%0d", math_q, lab_q);

    // read-before-write on math
    t_req = 1'b1; t_field = 2'd0; t_wdata = 8'd42;
    @(posedge clk); #1;
    s_req = 1'b1; s_field = 2'd0;
    @(negedge clk);
    check("rbw_gnt", t_gnt, 1);
    @(posedge clk); #1; t_req = 1'b0;
    @(negedge clk);
    check("rbw_valid", s_valid, 1);
    check("rbw_old", s_rdata, 12);
    @(posedge clk); #1; s_req = 1'b0;
    @(negedge clk);
    check("rbw_new", s_rdata, 42);
    @(posedge clk); #1;
    $display("rbw done: math=%0d", math_q);

    // reset during GRANT aborts the write
    t_req = 1'b1; t_field = 2'd0; t_wdata = 8'd7;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_gnt", t_gnt, 0);
    @(posedge clk); #1;
    rst = 1'b0; t_req = 1'b0;
    @(negedge clk);
    check("abort_math", math_q, 0);
    check("abort_rdata", s_rdata, 0);
    check("abort_zero", {t_gnt, t_err, p_gnt, s_valid, lab_locked, commit_cnt, lab_q, physics_q}, 0);
    @(posedge clk); #1;
    $display("abort done: math=%0d cnt=%0d", math_q, commit_cnt);

    // five commits saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      do_write(1'b0, 2'd1, 8'(i + 1), g, e, lat);
      check("sat_gnt", g, 1);
    end
    @(negedge clk);
    check("sat_cnt2", commit_cnt2, 3);
    check("sat_cnt8", commit_cnt, 5);
    @(posedge clk); #1;
    $display("saturation done: cnt8=%0d cnt2=%0d", commit_cnt, commit_cnt2);

    // randomized protocol-compliant traffic against the model
    saw_t = 1'b0; saw_p = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (t_req && saw_t) t_req = 1'b0;
      else if (!t_req && $urandom_range(2) == 0) begin
        t_req = 1'b1; t_field = 2'($urandom); t_wdata = 8'($urandom);
      end
      if (p_req && saw_p) p_req = 1'b0;
      else if (!p_req && $urandom_range(3) == 0) begin
        p_req = 1'b1; p_wdata = 8'($urandom);
      end
      s_req   = 1'($urandom_range(1));
      s_field = 2'($urandom);
      rst     = ($urandom_range(99) == 0);
      @(negedge clk);
      saw_t = t_gnt | t_err;
      saw_p = p_gnt;
      @(posedge clk); #1;
    end
    t_req = 1'b0; p_req = 1'b0; s_req = 1'b0; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("random phase done: cnt=%0d lock=%0d", commit_cnt, lab_locked);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
